// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Keeps one instruction-memory request in flight at a time. A fetched word is
// parked in a hold buffer while the hazard unit stalls. On a redirect the stage
// flushes IF/ID and drops the stale response before fetching the target.
module fetch_stage #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imemReq,
    output logic [PC_WIDTH-1:0]    imemAddr,
    input  logic                   imemValid,
    input  logic [INSTR_WIDTH-1:0] imemData,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirectPc,
    output logic                   ifidValid,
    output logic [INSTR_WIDTH-1:0] ifidInstr,
    output logic [PC_WIDTH-1:0]    ifidPc,
    output logic [PC_WIDTH-1:0]    ifidPcPlus1,
    output logic [3:0]             opcode
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_t                 state, state_next;
    logic [PC_WIDTH-1:0]    pc, pc_next;
    logic [PC_WIDTH-1:0]    req_addr, req_addr_next;
    logic [INSTR_WIDTH-1:0] hold_buf, hold_buf_next;
    logic [PC_WIDTH-1:0]    hold_pc, hold_pc_next;
    logic                   ifid_valid, ifid_valid_next;
    logic [INSTR_WIDTH-1:0] ifid_instr, ifid_instr_next;
    logic [PC_WIDTH-1:0]    ifid_pc, ifid_pc_next;
    logic [PC_WIDTH-1:0]    ifid_pc_plus1, ifid_pc_plus1_next;

    // Next-state and next-register logic; a redirect overrides everything else.
    always_comb begin
        state_next         = state;
        pc_next            = pc;
        req_addr_next      = req_addr;
        hold_buf_next      = hold_buf;
        hold_pc_next       = hold_pc;
        ifid_valid_next    = ifid_valid;
        ifid_instr_next    = ifid_instr;
        ifid_pc_next       = ifid_pc;
        ifid_pc_plus1_next = ifid_pc_plus1;

        case (state)
            IDLE: begin
                state_next = REQ;
                if (redirect) begin
                    ifid_valid_next = 1'b0;
                    pc_next         = redirectPc;
                    req_addr_next   = redirectPc;
                end else begin
                    req_addr_next = pc;
                end
            end

            REQ: begin
                if (redirect) begin
                    ifid_valid_next = 1'b0;
                    pc_next         = redirectPc;
                    if (imemValid) begin
                        req_addr_next = redirectPc;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (imemValid) begin
                    pc_next = req_addr + PC_ONE;
                    if (stall) begin
                        hold_buf_next = imemData;
                        hold_pc_next  = req_addr;
                        state_next    = HOLD;
                    end else begin
                        ifid_valid_next    = 1'b1;
                        ifid_instr_next    = imemData;
                        ifid_pc_next       = req_addr;
                        ifid_pc_plus1_next = req_addr + PC_ONE;
                        req_addr_next      = req_addr + PC_ONE;
                    end
                end else if (!stall) begin
                    ifid_valid_next = 1'b0;
                end
            end

            HOLD: begin
                if (redirect) begin
                    ifid_valid_next = 1'b0;
                    pc_next         = redirectPc;
                    req_addr_next   = redirectPc;
                    state_next      = REQ;
                end else if (!stall) begin
                    ifid_valid_next    = 1'b1;
                    ifid_instr_next    = hold_buf;
                    ifid_pc_next       = hold_pc;
                    ifid_pc_plus1_next = hold_pc + PC_ONE;
                    req_addr_next      = pc;
                    state_next         = REQ;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    ifid_valid_next = 1'b0;
                    pc_next         = redirectPc;
                end
                if (imemValid) begin
                    req_addr_next = redirect ? redirectPc : pc;
                    state_next    = REQ;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            req_addr      <= RESET_PC;
            hold_buf      <= '0;
            hold_pc       <= '0;
            ifid_valid    <= 1'b0;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus1 <= '0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            req_addr      <= req_addr_next;
            hold_buf      <= hold_buf_next;
            hold_pc       <= hold_pc_next;
            ifid_valid    <= ifid_valid_next;
            ifid_instr    <= ifid_instr_next;
            ifid_pc       <= ifid_pc_next;
            ifid_pc_plus1 <= ifid_pc_plus1_next;
        end
    end

    assign imemReq     = (state == REQ) || (state == DRAIN);
    assign imemAddr    = req_addr;
    assign ifidValid   = ifid_valid;
    assign ifidInstr   = ifid_instr;
    assign ifidPc      = ifid_pc;
    assign ifidPcPlus1 = ifid_pc_plus1;
    assign opcode      = ifid_valid ? ifid_instr[INSTR_WIDTH-1 -: 4] : 4'b0000;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: a cycle-by-cycle vector table followed by
// hand-written redirect and hold sequences. Expectations are sampled 1 time
// unit after each rising edge.
module tb_fetch_stage;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redirect;
        logic [7:0]  redirect_pc;
        logic        imem_valid;
        logic [31:0] imem_data;
        logic        exp_req;
        logic [7:0]  exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [7:0]  exp_pc;
        logic [7:0]  exp_pcp1;
        logic [3:0]  exp_op;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        imemReq;
    logic [7:0]  imemAddr;
    logic        imemValid;
    logic [31:0] imemData;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirectPc;
    logic        ifidValid;
    logic [31:0] ifidInstr;
    logic [7:0]  ifidPc;
    logic [7:0]  ifidPcPlus1;
    logic [3:0]  opcode;

    int   tests_run;
    int   tests_failed;
    vec_t vecs[$];

    fetch_stage #(
        .PC_WIDTH(8),
        .INSTR_WIDTH(32),
        .RESET_PC(8'h00)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imemReq(imemReq),
        .imemAddr(imemAddr),
        .imemValid(imemValid),
        .imemData(imemData),
        .stall(stall),
        .redirect(redirect),
        .redirectPc(redirectPc),
        .ifidValid(ifidValid),
        .ifidInstr(ifidInstr),
        .ifidPc(ifidPc),
        .ifidPcPlus1(ifidPcPlus1),
        .opcode(opcode)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic s, input logic rd, input logic [7:0] rpc,
                          input logic v, input logic [31:0] d, input logic e_req,
                          input logic [7:0] e_addr, input logic e_val, input logic [31:0] e_instr,
                          input logic [7:0] e_pc, input logic [7:0] e_pcp1, input logic [3:0] e_op);
        vec_t t;
        t.rst_n = r; t.stall = s; t.redirect = rd; t.redirect_pc = rpc;
        t.imem_valid = v; t.imem_data = d;
        t.exp_req = e_req; t.exp_addr = e_addr; t.exp_valid = e_val; t.exp_instr = e_instr;
        t.exp_pc = e_pc; t.exp_pcp1 = e_pcp1; t.exp_op = e_op;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic rd, input logic [7:0] rpc,
                                 input logic v, input logic [31:0] d);
        rst_n      = r;
        stall      = s;
        redirect   = rd;
        redirectPc = rpc;
        imemValid  = v;
        imemData   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic e_req, input logic [7:0] e_addr,
                               input logic e_val, input logic [31:0] e_instr, input logic [7:0] e_pc,
                               input logic [7:0] e_pcp1, input logic [3:0] e_op);
        checkField({tag, ".imemReq"},     {31'b0, imemReq},   {31'b0, e_req});
        checkField({tag, ".imemAddr"},    {24'b0, imemAddr},  {24'b0, e_addr});
        checkField({tag, ".ifidValid"},   {31'b0, ifidValid}, {31'b0, e_val});
        checkField({tag, ".ifidInstr"},   ifidInstr,          e_instr);
        checkField({tag, ".ifidPc"},      {24'b0, ifidPc},    {24'b0, e_pc});
        checkField({tag, ".ifidPcPlus1"}, {24'b0, ifidPcPlus1}, {24'b0, e_pcp1});
        checkField({tag, ".opcode"},      {28'b0, opcode},    {28'b0, e_op});
    endtask

    // Main stimulus: vector table first, then multi-cycle corner sequences.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n      = 1'b0;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPc = 8'h00;
        imemValid  = 1'b0;
        imemData   = 32'h0;

        //     rst stl rd  rpc    v  data            req addr   val instr          pc     pcp1   op
        addVec(0,  0,  0,  8'h00, 0, 32'h0000_0000,  0,  8'h00, 0,  32'h0000_0000, 8'h00, 8'h00, 4'h0);
        addVec(1,  0,  0,  8'h00, 0, 32'h0000_0000,  1,  8'h00, 0,  32'h0000_0000, 8'h00, 8'h00, 4'h0);
        addVec(1,  0,  0,  8'h00, 1, 32'h0000_0000,  1,  8'h01, 1,  32'h0000_0000, 8'h00, 8'h01, 4'h0);
        addVec(1,  0,  0,  8'h00, 1, 32'h1000_0001,  1,  8'h02, 1,  32'h1000_0001, 8'h01, 8'h02, 4'h1);
        addVec(1,  0,  0,  8'h00, 1, 32'h2000_0002,  1,  8'h03, 1,  32'h2000_0002, 8'h02, 8'h03, 4'h2);
        addVec(1,  0,  0,  8'h00, 1, 32'h3000_0003,  1,  8'h04, 1,  32'h3000_0003, 8'h03, 8'h04, 4'h3);
        addVec(1,  0,  0,  8'h00, 0, 32'h0000_0000,  1,  8'h04, 0,  32'h3000_0003, 8'h03, 8'h04, 4'h0);
        addVec(1,  0,  0,  8'h00, 1, 32'h4000_0004,  1,  8'h05, 1,  32'h4000_0004, 8'h04, 8'h05, 4'h4);
        addVec(1,  1,  0,  8'h00, 1, 32'h5000_0005,  0,  8'h05, 1,  32'h4000_0004, 8'h04, 8'h05, 4'h4);
        addVec(1,  1,  0,  8'h00, 0, 32'h0000_0000,  0,  8'h05, 1,  32'h4000_0004, 8'h04, 8'h05, 4'h4);
        addVec(1,  1,  0,  8'h00, 0, 32'h0000_0000,  0,  8'h05, 1,  32'h4000_0004, 8'h04, 8'h05, 4'h4);
        addVec(1,  0,  0,  8'h00, 0, 32'h0000_0000,  1,  8'h06, 1,  32'h5000_0005, 8'h05, 8'h06, 4'h5);
        addVec(1,  0,  0,  8'h00, 1, 32'h6000_0006,  1,  8'h07, 1,  32'h6000_0006, 8'h06, 8'h07, 4'h6);
        addVec(1,  0,  1,  8'h10, 1, 32'h7000_0007,  1,  8'h10, 0,  32'h6000_0006, 8'h06, 8'h07, 4'h0);
        addVec(1,  0,  1,  8'h40, 0, 32'h0000_0000,  1,  8'h10, 0,  32'h6000_0006, 8'h06, 8'h07, 4'h0);
        addVec(1,  0,  0,  8'h00, 0, 32'h0000_0000,  1,  8'h10, 0,  32'h6000_0006, 8'h06, 8'h07, 4'h0);
        addVec(1,  0,  0,  8'h00, 1, 32'hA000_0010,  1,  8'h40, 0,  32'h6000_0006, 8'h06, 8'h07, 4'h0);
        addVec(1,  0,  0,  8'h00, 1, 32'h7000_0040,  1,  8'h41, 1,  32'h7000_0040, 8'h40, 8'h41, 4'h7);
        addVec(1,  1,  1,  8'hFE, 1, 32'hB000_0041,  1,  8'hFE, 0,  32'h7000_0040, 8'h40, 8'h41, 4'h0);
        addVec(1,  0,  0,  8'h00, 1, 32'h8000_00FE,  1,  8'hFF, 1,  32'h8000_00FE, 8'hFE, 8'hFF, 4'h8);
        addVec(1,  0,  0,  8'h00, 1, 32'h9000_00FF,  1,  8'h00, 1,  32'h9000_00FF, 8'hFF, 8'h00, 4'h9);
        addVec(1,  1,  0,  8'h00, 1, 32'hC000_0000,  0,  8'h00, 1,  32'h9000_00FF, 8'hFF, 8'h00, 4'h9);
        addVec(0,  1,  0,  8'h00, 0, 32'h0000_0000,  0,  8'h00, 0,  32'h0000_0000, 8'h00, 8'h00, 4'h0);
        addVec(1,  1,  0,  8'h00, 0, 32'h0000_0000,  1,  8'h00, 0,  32'h0000_0000, 8'h00, 8'h00, 4'h0);
        addVec(1,  0,  0,  8'h00, 1, 32'hD000_0000,  1,  8'h01, 1,  32'hD000_0000, 8'h00, 8'h01, 4'hD);

        @(negedge clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].stall, vecs[i].redirect, vecs[i].redirect_pc,
                          vecs[i].imem_valid, vecs[i].imem_data);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid,
                        vecs[i].exp_instr, vecs[i].exp_pc, vecs[i].exp_pcp1, vecs[i].exp_op);
        end

        // Stall with no response keeps IF/ID; response under stall parks in HOLD;
        // redirect from HOLD flushes and fetches the target with no extra cycle.
        applyStimulus(1, 1, 0, 8'h00, 0, 32'h0000_0000);
        checkOutput("holdA1", 1, 8'h01, 1, 32'hD000_0000, 8'h00, 8'h01, 4'hD);
        applyStimulus(1, 1, 0, 8'h00, 1, 32'hE000_0001);
        checkOutput("holdA2", 0, 8'h01, 1, 32'hD000_0000, 8'h00, 8'h01, 4'hD);
        applyStimulus(1, 1, 1, 8'h20, 0, 32'h0000_0000);
        checkOutput("holdA3", 1, 8'h20, 0, 32'hD000_0000, 8'h00, 8'h01, 4'h0);
        applyStimulus(1, 0, 0, 8'h00, 1, 32'hF000_0020);
        checkOutput("holdA4", 1, 8'h21, 1, 32'hF000_0020, 8'h20, 8'h21, 4'hF);

        // Two redirects while a request is outstanding: the newest target wins
        // once the stale response drains.
        applyStimulus(1, 0, 1, 8'h30, 0, 32'h0000_0000);
        checkOutput("drainB1", 1, 8'h21, 0, 32'hF000_0020, 8'h20, 8'h21, 4'h0);
        applyStimulus(1, 0, 1, 8'h50, 0, 32'h0000_0000);
        checkOutput("drainB2", 1, 8'h21, 0, 32'hF000_0020, 8'h20, 8'h21, 4'h0);
        applyStimulus(1, 0, 0, 8'h00, 1, 32'h1234_5678);
        checkOutput("drainB3", 1, 8'h50, 0, 32'hF000_0020, 8'h20, 8'h21, 4'h0);
        applyStimulus(1, 0, 0, 8'h00, 1, 32'h3ABC_0050);
        checkOutput("drainB4", 1, 8'h51, 1, 32'h3ABC_0050, 8'h50, 8'h51, 4'h3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
